// File: rtl/dout_mem_reader.sv
// dout_mem_reader: streams the output data buffer to the export path.
// A start pulse reads a clamped number of words from the buffer's
// synchronous read port, starting at index 0. Each word is split into
// pixels, most significant lane first, and sent over a valid/ready stream.
module dout_mem_reader #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 10000,
    parameter int PIXEL = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] count,
    output logic             mem_re,
    output logic [WIDTH-1:0] mem_addr,
    input  logic [WIDTH-1:0] mem_rd,
    output logic [PIXEL-1:0] pix_data,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic             pix_last,
    output logic             busy,
    output logic             done
);

    localparam int LANES  = WIDTH / PIXEL;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [WIDTH-1:0]  DEPTH_W   = WIDTH'(DEPTH);
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LANES - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_SEND  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [WIDTH-1:0]  idx_q,   idx_d;
    logic [WIDTH-1:0]  cnt_q,   cnt_d;
    logic [LANE_W-1:0] lane_q,  lane_d;
    logic [WIDTH-1:0]  shift_q, shift_d;

    logic [WIDTH-1:0] cnt_clamp;
    logic             lane_last;
    logic             word_last;
    logic             hs;

    // Clamping here guarantees no read ever addresses past the buffer end.
    assign cnt_clamp = (count > DEPTH_W) ? DEPTH_W : count;

    // cnt_q is nonzero whenever a word is in flight, so cnt_q-1 never wraps.
    assign lane_last = (lane_q == LANE_LAST);
    assign word_last = (idx_q == (cnt_q - WIDTH'(1)));
    assign hs        = (state_q == S_SEND) && pix_ready;

    // Next-state and datapath update for the transfer sequencer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        lane_d  = lane_q;
        shift_d = shift_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cnt_clamp == '0) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = cnt_clamp;
                        idx_d   = '0;
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                shift_d = mem_rd;
                lane_d  = '0;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (hs) begin
                    shift_d = shift_q << PIXEL;
                    lane_d  = lane_q + LANE_W'(1);
                    if (lane_last) begin
                        if (word_last) begin
                            state_d = S_DONE;
                        end else begin
                            idx_d   = idx_q + WIDTH'(1);
                            state_d = S_FETCH;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; an asynchronous reset abandons any transfer in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            lane_q  <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            lane_q  <= lane_d;
            shift_q <= shift_d;
        end
    end

    // mem_addr follows idx, which only moves when entering FETCH, so it
    // holds the last read index everywhere else.
    assign mem_re    = (state_q == S_FETCH);
    assign mem_addr  = idx_q;
    assign pix_valid = (state_q == S_SEND);
    assign pix_data  = pix_valid ? shift_q[WIDTH-1 -: PIXEL] : '0;
    assign pix_last  = pix_valid && lane_last && word_last;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_dout_mem_reader.sv
// Bench for dout_mem_reader: buffer model, pixel-order reference queue,
// handshake stability, read sequence and completion timing.
module tb_dout_mem_reader;

    localparam int WIDTH = 24;
    localparam int DEPTH = 10000;
    localparam int PIXEL = 8;
    localparam int LANES = WIDTH / PIXEL;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] count = '0;
    logic             mem_re;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_rd = '0;
    logic [PIXEL-1:0] pix_data;
    logic             pix_valid;
    logic             pix_ready = 1'b0;
    logic             pix_last;
    logic             busy;
    logic             done;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] mem [DEPTH];

    dout_mem_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PIXEL(PIXEL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .count(count),
        .mem_re(mem_re), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_last(pix_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // synchronous read port of the buffer
    always @(posedge clk) begin
        if (mem_re) mem_rd <= mem[int'(mem_addr) % DEPTH];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({mem_re, mem_addr, pix_data, pix_valid, pix_last, busy, done});
    endfunction

    function automatic logic rdy(input int mode, input int k);
        case (mode)
            0:       return 1'b1;
            1:       return (k % 3) == 0;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // One transfer: cnt words, ready pattern mode, extra start pulses at
    // cycles mid1/mid2 (count=5), async reset at cycle abort_at, and an
    // expected done cycle (or -1 to skip the timing check).
    task automatic run(input int cnt, input int mode, input int mid1, input int mid2,
                       input int abort_at, input int exp_done);
        logic [PIXEL-1:0] q[$];
        logic [WIDTH-1:0] word;
        logic [PIXEL-1:0] e;
        logic [9:0]       prev;
        int n, reads, last_addr, budget;
        bit fin, prev_stall;
        n = (cnt > DEPTH) ? DEPTH : cnt;
        for (int w = 0; w < n; w++) begin
            word = mem[w];
            for (int l = 0; l < LANES; l++)
                q.push_back(PIXEL'(word >> ((LANES - 1 - l) * PIXEL)));
        end
        reads = 0; last_addr = -1; fin = 0; prev_stall = 0; prev = '0;
        budget = 30 * n + 20;
        @(posedge clk); #1;
        start = 1'b1; count = WIDTH'(cnt); pix_ready = rdy(mode, 0);
        for (int cyc = 0; cyc < budget && !fin; cyc++) begin
            @(negedge clk);
            if (cyc == 0) chk("busy_before", 64'(busy), 0);
            if (cyc == 1) chk("busy_rise", 64'(busy), 1);
            if (mem_re) begin
                chk("rd_addr", 64'(mem_addr), 64'(reads));
                last_addr = int'(mem_addr);
                reads++;
            end
            if (prev_stall) chk("hold", 64'({pix_valid, pix_last, pix_data}), 64'(prev));
            if (pix_valid && pix_ready) begin
                if (q.size() == 0) begin
                    chk("extra_pix", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("pix", 64'(pix_data), 64'(e));
                    chk("last", 64'(pix_last), 64'(q.size() == 0));
                end
            end
            prev_stall = pix_valid && !pix_ready;
            prev = {pix_valid, pix_last, pix_data};
            if (done) begin
                fin = 1;
                chk("pix_left", 64'(q.size()), 0);
                chk("reads", 64'(reads), 64'(n));
                if (n > 0) chk("last_addr", 64'(last_addr), 64'(n - 1));
                if (exp_done >= 0) chk("done_cyc", 64'(cyc), 64'(exp_done));
            end else begin
                @(posedge clk); #1;
                start = (cyc + 1 == mid1) || (cyc + 1 == mid2);
                if (start) count = WIDTH'(5);
                pix_ready = rdy(mode, cyc + 1);
                if (cyc + 1 == abort_at) begin
                    #2 rst_n = 1'b0;
                    #1 chk("rst_async", outs(), 0);
                    repeat (3) begin
                        @(negedge clk);
                        chk("rst_nodone", 64'({busy, done}), 0);
                    end
                    @(posedge clk); #2 rst_n = 1'b1;
                    fin = 1;
                end
            end
        end
        if (!fin) chk("timeout", 0, 1);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'($urandom);
        mem[0] = 24'hAABBCC;
        mem[1] = 24'h112233;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", outs(), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        run(2, 0, -1, -1, -1, 11);        // basic order and latency
        run(2, 1, -1, -1, -1, -1);        // 1,0,0 backpressure
        run(0, 0, -1, -1, -1, 1);         // empty transfer
        run(2, 0, 5, 11, -1, 11);         // start mid-SEND and on done cycle
        run(5, 0, -1, -1, -1, 26);        // start on cycle after done
        run(3, 1, -1, -1, 4, -1);         // reset during SEND of word 0
        run(2, 0, -1, -1, -1, 11);        // fresh transfer from index 0
        for (int k = 0; k < 4; k++)
            run(int'($urandom_range(1, 8)), 2, -1, -1, -1, -1);
        run(20000, 0, -1, -1, -1, 5 * DEPTH + 1);  // clamped to DEPTH

        @(posedge clk); #1 start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("idle_after", 64'({mem_re, pix_valid, busy, done}), 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dout_mem_reader.md
Name: dout_mem_reader

Overview:
- Read-side streamer for the output data buffer that the vector processor fills.
- On a start pulse, it reads a programmed number of WIDTH-bit words from the buffer's synchronous read port, starting at buffer index 0.
- Each word is unpacked into WIDTH/PIXEL pixels, most significant lane first, and emitted over a valid/ready stream to the export path (UART/host bridge).
- It replaces the file dump for synthesis and hardware bring-up.

Parameters:
- WIDTH, 24, buffer word width in bits.
- DEPTH, 10000, buffer depth in words; index range 0..DEPTH-1.
- PIXEL, 8, pixel width in bits; WIDTH must be an integer multiple of PIXEL. LANES = WIDTH/PIXEL (3 by default).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that begins a transfer; ignored while busy=1.
- count  in  WIDTH  number of words to stream; sampled on the accepted start; values above DEPTH are clamped to DEPTH.
- mem_re  out  1  buffer read enable, high for exactly one cycle per word.
- mem_addr  out  WIDTH  buffer index (0-based, no +24 bus offset).
- mem_rd  in  WIDTH  buffer read data, valid the cycle after mem_re.
- pix_data  out  PIXEL  current pixel.
- pix_valid  out  1  pix_data is valid.
- pix_ready  in  1  downstream accepts the pixel.
- pix_last  out  1  current pixel is the last pixel of the transfer; qualified by pix_valid.
- busy  out  1  a transfer is in progress.
- done  out  1  one-cycle pulse when the transfer completes.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - All outputs are 0: mem_re, mem_addr, pix_data, pix_valid, pix_last, busy, done.
  - Word index, lane counter, latched count and shift register are cleared.
- Reset mid-transfer: the transfer is abandoned immediately, no done pulse is issued, and the block is in IDLE after rst_n deasserts.
- The handshake completes on any rising edge where pix_valid=1 and pix_ready=1.
- States:
  - IDLE: busy=0.
    - start=1 and clamped count=0 -> DONE, with no reads and no pixels.
    - start=1 and clamped count>0 -> latch the clamped count, idx=0, go to FETCH.
  - FETCH: one cycle; mem_re=1, mem_addr=idx. Next state is LOAD.
  - LOAD: one cycle; mem_rd is captured into the shift register, lane=0. Next state is SEND.
  - SEND: pix_valid=1; pix_data = shift register bits [WIDTH-1 -: PIXEL].
    - On each handshake: shift left by PIXEL and increment lane.
    - On the handshake with lane=LANES-1 and idx=count-1 -> DONE.
    - On the handshake with lane=LANES-1 otherwise -> idx+1, go to FETCH.
    - Without a handshake, pix_data, pix_valid and pix_last hold stable (no retraction).
  - DONE: done=1 for one cycle, busy=0 from the next cycle, return to IDLE.
- busy=1 in FETCH, LOAD, SEND and DONE; it rises the cycle after the accepted start.
- pix_last=1 only in SEND when lane=LANES-1 and idx=count-1.
- Latency:
  - First pixel valid 3 cycles after the start cycle (start edge, FETCH, LOAD, SEND).
  - Per-word overhead is 2 cycles. With pix_ready held high, N words take 5N+1 cycles from start to the done pulse.
- start is ignored during any state other than IDLE, including on the done cycle. A new start is accepted on the cycle after done.
- mem_addr holds its last value outside FETCH; mem_re=0 outside FETCH.
- The block never reads index ≥ DEPTH, because count is clamped.
- Arithmetic:
  - idx and the count comparison are unsigned, WIDTH bits.
  - lane is ceil(log2(LANES)) bits and wraps to 0 on LOAD only.
- Downstream may hold pix_ready=0 indefinitely. The block stalls in SEND with no further memory reads.

Test Plan:
- Basic order: buffer[0]=0xAABBCC, buffer[1]=0x112233, count=2, pix_ready=1.
  - Pixels are AA, BB, CC, 11, 22, 33.
  - pix_last is high only on 33.
  - done pulses exactly 11 cycles after start; mem_re pulses twice, at addr 0 then 1.
- Backpressure: same data with pix_ready toggling 1,0,0,1,…
  - pix_data and pix_valid stay stable while stalled.
  - No pixel is lost or duplicated, and there is no extra mem_re.
  - Order is identical to the basic-order case.
- Boundaries:
  - count=0: done pulses 1 cycle after start, with no mem_re and no pix_valid.
  - count=20000: clamped; exactly 10000 reads, last addr 9999, then done.
- Start while busy: a second start pulse is issued mid-SEND with count=5.
  - It is ignored; the original count=2 transfer completes normally.
  - A start on the cycle after done launches a new transfer.
- Reset mid-transfer: rst_n is pulled low asynchronously (between edges) during SEND of word 0.
  - All outputs go to 0 immediately.
  - No done pulse is issued.
  - A fresh start after release streams from index 0.
